// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-digit counter: digit type, bounds, clamp helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;
    localparam digit_t BCD_MIN = 4'd0;

    // Any 4-bit code above 9 is not a decimal digit; pin it to the largest legal one.
    function automatic digit_t bcd_clamp(input digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: next-digit value plus carry/borrow out.
// Latency: purely combinational, no registers.
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports: digit_in (current digit), step (count enable), dir (0 up / 1 down),
//        cin (carry/borrow from lower digit), digit_out (next digit), cout.
module bcd_digit
    import bcd_pkg::*;
(
    input  digit_t digit_in,
    input  logic   step,
    input  logic   dir,
    input  logic   cin,
    output digit_t digit_out,
    output logic   cout
);

    always_comb begin
        digit_out = digit_in;
        cout      = 1'b0;
        if (step && cin) begin
            if (!dir) begin
                // A 9 rolls to 0 and hands the increment to the next digit.
                if (digit_in >= BCD_MAX) begin
                    digit_out = BCD_MIN;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in + 4'd1;
                end
            end else begin
                // A 0 rolls to 9 and borrows from the next digit.
                if (digit_in == BCD_MIN) begin
                    digit_out = BCD_MAX;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/counter_bcd_ndigit.sv
// N-digit BCD up/down counter with load, enable, wrap/saturate and boundary pulses.
// Latency: 1 cycle from sampled inputs to count and all flags (all registered).
// Backpressure: none; a step, load or reset is accepted every cycle.
//
// Ports: clk, rst (sync, active high), en, dir (0 up / 1 down), sat (1 = saturate),
//        load + data (BCD, digits >9 clamped), count, sup, inf, load_err.
module counter_bcd_ndigit
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  sat,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   count,
    output logic                  sup,
    output logic                  inf,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                sup_q, sup_d;
    logic                inf_q, inf_d;
    logic                load_err_q, load_err_d;

    // Ripple chain: chain[i] is the carry/borrow into digit i. Digit 0 always
    // steps when enabled, so its input is tied high.
    logic [DIGITS:0]     chain;
    logic [4*DIGITS-1:0] step_val;

    assign chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit_in  (count_q[4*g +: 4]),
            .step      (en),
            .dir       (dir),
            .cin       (chain[g]),
            .digit_out (step_val[4*g +: 4]),
            .cout      (chain[g+1])
        );
    end

    // Load path: clamp every digit and note whether any needed clamping.
    logic [4*DIGITS-1:0] load_val;
    logic                load_bad;

    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            load_val[4*i +: 4] = bcd_clamp(data[4*i +: 4]);
            if (data[4*i +: 4] > BCD_MAX) begin
                load_bad = 1'b1;
            end
        end
    end

    // A carry/borrow out of the top digit means every digit sat at the
    // boundary value for this direction: all 9s going up, all 0s going down.
    // In that case step_val is already the wrapped value.
    always_comb begin
        count_d    = count_q;
        sup_d      = 1'b0;
        inf_d      = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            count_d    = load_val;
            load_err_d = load_bad;
        end else if (en) begin
            if (chain[DIGITS]) begin
                sup_d   = ~dir;
                inf_d   = dir;
                count_d = sat ? count_q : step_val;
            end else begin
                count_d = step_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            sup_q      <= 1'b0;
            inf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            sup_q      <= sup_d;
            inf_q      <= inf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign sup      = sup_q;
    assign inf      = inf_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_counter_bcd_ndigit.sv
// Scoreboard bench for counter_bcd_ndigit with an integer-valued reference model.
// Latency: expectations are pushed at stimulus time, popped one cycle later.
// Backpressure: none; the DUT produces a result every cycle.
module tb_counter_bcd_ndigit;

    localparam int D = 2;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b0;
    logic         sat = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] count;
    logic         sup;
    logic         inf;
    logic         load_err;

    always #5 clk = ~clk;

    counter_bcd_ndigit #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .sat      (sat),
        .load     (load),
        .data     (data),
        .count    (count),
        .sup      (sup),
        .inf      (inf),
        .load_err (load_err)
    );

    typedef struct packed {
        logic [W-1:0] count;
        logic         sup;
        logic         inf;
        logic         lerr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mval   = 0;   // model count as a plain decimal integer
    int   maxv;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Apply one cycle of inputs and record what the counter must show after the edge.
    task automatic step(input logic r, input logic l, input logic e, input logic d,
                        input logic s, input logic [W-1:0] dt);
        exp_t x;
        int   nib;
        @(negedge clk);
        rst  = r;
        load = l;
        en   = e;
        dir  = d;
        sat  = s;
        data = dt;
        x = '0;
        if (r) begin
            mval = 0;
        end else if (l) begin
            mval = 0;
            for (int i = D - 1; i >= 0; i--) begin
                nib = int'(dt[4*i +: 4]);
                if (nib > 9) begin
                    nib    = 9;
                    x.lerr = 1'b1;
                end
                mval = mval * 10 + nib;
            end
        end else if (e) begin
            if (!d) begin
                if (mval == maxv) begin
                    x.sup = 1'b1;
                    if (!s) mval = 0;
                end else begin
                    mval = mval + 1;
                end
            end else begin
                if (mval == 0) begin
                    x.inf = 1'b1;
                    if (!s) mval = maxv;
                end else begin
                    mval = mval - 1;
                end
            end
        end
        x.count = to_bcd(mval);
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: one result per cycle, checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (count !== e.count) begin
                    errors++;
                    $display("FAIL count: got %h expected %h", count, e.count);
                end
                checks++;
                if (sup !== e.sup) begin
                    errors++;
                    $display("FAIL sup: got %b expected %b (count %h)", sup, e.sup, e.count);
                end
                checks++;
                if (inf !== e.inf) begin
                    errors++;
                    $display("FAIL inf: got %b expected %b (count %h)", inf, e.inf, e.count);
                end
                checks++;
                if (load_err !== e.lerr) begin
                    errors++;
                    $display("FAIL load_err: got %b expected %b (count %h)", load_err, e.lerr, e.count);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        maxv = 1;
        for (int i = 0; i < D; i++) maxv = maxv * 10;
        maxv = maxv - 1;

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(5);

        // Up wrap: 98, 99, 00 with sup on the wrap
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h97);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Down saturate: 00, 00, 00 with inf on the held cycles
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);

        // Down wrap from 00 to 99, then saturated up at 99
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);

        // Carry and borrow across digits
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h19);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);

        // Clamp, load_err for exactly one cycle
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFC);

        // Priority: load beats a boundary step, reset beats load
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        idle(1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, l;
            logic [W-1:0] dt;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 9) == 0);
            dt = W'($urandom);
            step(r, l, 1'($urandom), 1'($urandom), 1'($urandom), dt);
        end
        idle(1);

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
